rgb_sinp: RTL
=============

// Module: rgb_sinp
// PURPOSE
//  WS2812b serial receiver: samples the single-wire LED data line, decodes
//  bits by high-pulse width, and assembles 24-bit G-R-B pixel words. Each
//  word, and each detected stream reset, is pushed as a 32-bit status+data
//  word into a write FIFO. It is the input stage feeding the RGBW serial
//  transmitter's read FIFO.
// PARAMETERS
//  COUNTER_MAX       7800  saturation value of pulse counters; sets counter width
//  STREAM_RESET_CLKS 4800  low clocks that signal a stream reset (50 us @ 96 MHz)
//  MIN_HIGH_CLKS     10    high pulses shorter than this are glitches and are ignored
//  BIT_THRESH_CLKS   58    high < this decodes as "0"; high >= this decodes as "1"
//  MAX_HIGH_CLKS     150   high longer than this is a frame error
// PORTS
//  clk              in   1   96 MHz clock, synchronous with FIFO w_clk
//  rst              in   1   asynchronous, active-high reset
//  in_sig           in   1   serial line input, asynchronous to clk
//  in_wr_fifo_full  in   1   FIFO write-full flag
//  out_wr_fifo_en   out  1   FIFO write strobe, 1-clk pulse
//  out_wr_fifo_data out  32  [31]=valid, [30]=stream_reset, [29]=drop flag,
//                            [28:24]=0, [23:16]=G, [15:8]=R, [7:0]=B
//  out_frame_err    out  1   1-clk pulse on an over-long high pulse
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, bit count 0, state S_SYNC. Reset
//    mid-frame discards partial bits; no FIFO write is issued.
//  - in_sig passes through a 2-flop synchronizer (sig_s) plus a delay flop
//    (sig_d). Rise = sig_s & ~sig_d. Fall = ~sig_s & sig_d.
//  - hi_cnt and lo_cnt saturate at COUNTER_MAX. Each restarts at 1 on the
//    edge cycle that opens its level.
//  - S_SYNC: wait for line low. A rise restarts lo_cnt. When lo_cnt ==
//    STREAM_RESET_CLKS: emit a reset word, go to S_LOW.
//  - S_LOW: on a rise, go to S_HIGH. When lo_cnt == STREAM_RESET_CLKS
//    (fires once per low period): emit a reset word and clear the bit count
//    (partial bits are discarded).
//  - S_HIGH: on a fall, classify hi_cnt:
//    - hi_cnt < MIN_HIGH_CLKS: glitch. No bit; go to S_LOW.
//    - hi_cnt < BIT_THRESH_CLKS: shift in 0.
//    - hi_cnt <= MAX_HIGH_CLKS: shift in 1.
//    Bits shift in MSB first, in G, R, B order.
//  - S_HIGH, too long: when hi_cnt reaches MAX_HIGH_CLKS+1 while still high,
//    pulse out_frame_err, discard partial bits, go to S_SYNC.
//  - The 24th bit completes a data word {1,0,drop,5'b0,GRB}. The bit count
//    returns to 0.
//  - A reset word is {1,1,drop,29'b0}.
//  - Write timing: out_wr_fifo_en pulses in the cycle after the completing
//    event. out_wr_fifo_data holds the word in that cycle and holds its value
//    afterwards.
//  - FIFO full: if in_wr_fifo_full=1 in the write cycle, en stays 0 and the
//    word is dropped. There is no retry.
//  - Latency: the fall of bit 24 at the pin gives en 4 clks later
//    (2 sync + 1 edge + 1 register).
// CONFIGURATION
//  RGB_SINP_DROP_FLAG_EN
//    - Defined: a sticky drop flag sets whenever a word is dropped because
//      the FIFO is full. Bit 29 of the next successfully written word carries
//      the flag, and that write clears it.
//    - Undefined: no flag logic; bit 29 is always 0.
// TESTING
//  1 Line low 4800 clks after reset -> one write 32'hC000_0000.
//  2 After sync, 24 bits of GRB=0xFF0080 (0: 38 hi/77 lo; 1: 77 hi/38 lo)
//    -> one write 32'h80FF_0080, 4 clks after the last fall.
//  3 5-clk high glitch mid-word, then remaining bits -> glitch ignored,
//    word decodes correctly.
//  4 12 bits, then 4800 clks low -> no data write, one 32'hC000_0000,
//    next 24 bits decode cleanly.
//  5 200-clk high pulse -> out_frame_err 1-clk pulse, no write until
//    4800 clks low are seen.
//  6 in_wr_fifo_full=1 during a word's write, then 0 -> word dropped; the
//    next word has bit29=1 with _EN defined, 0 without it.

Source files
------------

// File: rtl/rgb_sinp_if.sv
// Write-FIFO port bundle for the WS2812b receiver.
// The receiver is the master (writer); the FIFO side is the slave.
interface rgb_sinp_if;
   logic        in_wr_fifo_full;
   logic        out_wr_fifo_en;
   logic [31:0] out_wr_fifo_data;

   modport master (
      input  in_wr_fifo_full,
      output out_wr_fifo_en,
      output out_wr_fifo_data
   );

   modport slave (
      output in_wr_fifo_full,
      input  out_wr_fifo_en,
      input  out_wr_fifo_data
   );
endinterface

// File: rtl/rgb_sinp.sv
// WS2812b serial receiver: decodes high-pulse widths into 24-bit GRB words and
// stream-reset markers, written to a FIFO. Optional macro: RGB_SINP_DROP_FLAG_EN.
//
// state  | meaning
// S_SYNC | waiting for a full stream-reset low period before decoding
// S_LOW  | line low between bits; watches for stream reset
// S_HIGH | line high; measuring pulse width
module rgb_sinp #(
   parameter int COUNTER_MAX       = 7800,
   parameter int STREAM_RESET_CLKS = 4800,
   parameter int MIN_HIGH_CLKS     = 10,
   parameter int BIT_THRESH_CLKS   = 58,
   parameter int MAX_HIGH_CLKS     = 150
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_sig,
   rgb_sinp_if.master wr_fifo,
   output logic       out_frame_err
);

   localparam int            CW        = $clog2(COUNTER_MAX + 1);
   localparam logic [CW-1:0] L_CNT_MAX = CW'(COUNTER_MAX);
   localparam logic [CW-1:0] L_RST_M1  = CW'(STREAM_RESET_CLKS - 1);
   localparam logic [CW-1:0] L_MIN     = CW'(MIN_HIGH_CLKS);
   localparam logic [CW-1:0] L_THRESH  = CW'(BIT_THRESH_CLKS);
   localparam logic [CW-1:0] L_MAXH    = CW'(MAX_HIGH_CLKS);
   localparam logic [CW-1:0] L_OVER    = CW'(MAX_HIGH_CLKS + 1);

   typedef enum logic [1:0] {
      S_SYNC,
      S_LOW,
      S_HIGH
   } state_t;

   logic          r_sig_meta;
   logic          r_sig_s;
   logic          r_sig_d;
   logic [CW-1:0] r_hi_cnt;
   logic [CW-1:0] r_lo_cnt;
   state_t        r_state;
   logic [4:0]    r_bit_cnt;
   logic [22:0]   r_shift;
   logic          r_wr_req;
   logic          r_wr_rst;
   logic [23:0]   r_wr_grb;

   logic w_rise;
   logic w_fall;
   logic w_lo_hit;
   logic w_bit;
   logic w_drop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sig_meta <= 1'b0;
         r_sig_s    <= 1'b0;
         r_sig_d    <= 1'b0;
      end else begin
         r_sig_meta <= in_sig;
         r_sig_s    <= r_sig_meta;
         r_sig_d    <= r_sig_s;
      end
   end

   assign w_rise = r_sig_s & ~r_sig_d;
   assign w_fall = ~r_sig_s & r_sig_d;
   // Fires on the cycle lo_cnt steps onto the reset length, so once per low period.
   assign w_lo_hit = ~r_sig_s & ~r_sig_d & (r_lo_cnt == L_RST_M1);
   assign w_bit    = (r_hi_cnt >= L_THRESH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi_cnt <= '0;
         r_lo_cnt <= '0;
      end else begin
         if (w_rise) begin
            r_hi_cnt <= CW'(1);
         end else if (r_sig_s && (r_hi_cnt != L_CNT_MAX)) begin
            r_hi_cnt <= r_hi_cnt + CW'(1);
         end

         if (w_fall) begin
            r_lo_cnt <= CW'(1);
         end else if (w_rise && (r_state == S_SYNC)) begin
            r_lo_cnt <= '0;
         end else if (!r_sig_s && (r_lo_cnt != L_CNT_MAX)) begin
            r_lo_cnt <= r_lo_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_SYNC;
         r_bit_cnt     <= '0;
         r_shift       <= '0;
         r_wr_req      <= 1'b0;
         r_wr_rst      <= 1'b0;
         r_wr_grb      <= '0;
         out_frame_err <= 1'b0;
      end else begin
         r_wr_req      <= 1'b0;
         out_frame_err <= 1'b0;
         case (r_state)
            S_SYNC: begin
               if (w_lo_hit) begin
                  r_wr_req  <= 1'b1;
                  r_wr_rst  <= 1'b1;
                  r_wr_grb  <= '0;
                  r_bit_cnt <= '0;
                  r_state   <= S_LOW;
               end
            end
            S_LOW: begin
               if (w_lo_hit) begin
                  r_wr_req  <= 1'b1;
                  r_wr_rst  <= 1'b1;
                  r_wr_grb  <= '0;
                  r_bit_cnt <= '0;
               end
               if (w_rise) begin
                  r_state <= S_HIGH;
               end
            end
            S_HIGH: begin
               if (w_fall) begin
                  r_state <= S_LOW;
                  if (r_hi_cnt < L_MIN) begin
                     r_state <= S_LOW;
                  end else if (r_hi_cnt <= L_MAXH) begin
                     r_shift <= {r_shift[21:0], w_bit};
                     if (r_bit_cnt == 5'd23) begin
                        r_wr_req  <= 1'b1;
                        r_wr_rst  <= 1'b0;
                        r_wr_grb  <= {r_shift, w_bit};
                        r_bit_cnt <= '0;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                     end
                  end else begin
                     // Fell on the very cycle the count crossed the limit.
                     out_frame_err <= 1'b1;
                     r_bit_cnt     <= '0;
                     r_state       <= S_SYNC;
                  end
               end else if (r_hi_cnt == L_OVER) begin
                  out_frame_err <= 1'b1;
                  r_bit_cnt     <= '0;
                  r_state       <= S_SYNC;
               end
            end
            default: begin
               r_state <= S_SYNC;
            end
         endcase
      end
   end

`ifdef RGB_SINP_DROP_FLAG_EN
   logic r_drop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop <= 1'b0;
      end else if (r_wr_req) begin
         r_drop <= wr_fifo.in_wr_fifo_full;
      end
   end

   assign w_drop = r_drop;
`else
   assign w_drop = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_fifo.out_wr_fifo_en   <= 1'b0;
         wr_fifo.out_wr_fifo_data <= '0;
      end else begin
         wr_fifo.out_wr_fifo_en <= r_wr_req & ~wr_fifo.in_wr_fifo_full;
         if (r_wr_req && !wr_fifo.in_wr_fifo_full) begin
            wr_fifo.out_wr_fifo_data <= {1'b1, r_wr_rst, w_drop, 5'b0, r_wr_grb};
         end
      end
   end

endmodule
